resp_formatter: RTL and testbench
=================================

RESP_FORMATTER -- requirements
Module: resp_formatter

Interface
REQ-001 clk  input  1  single system clock; all logic on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 resp_ok  input  1  1-cycle pulse; write completed ('K').
REQ-004 resp_data  input  1  1-cycle pulse; read completed ('D').
REQ-005 resp_err  input  1  1-cycle pulse; command failed ('E').
REQ-006 resp_addr  input  8  address of completed command; valid with pulse.
REQ-007 resp_data_byte  input  8  read data; valid with resp_data.
REQ-008 resp_err_code  input  8  error code; valid with resp_err.
REQ-009 tx_busy  input  1  UART transmitter busy; rises the cycle after tx_start and stays high until the byte has been shifted out.
REQ-010 tx_start  output  1  1-cycle pulse requesting transmission of tx_data.
REQ-011 tx_data  output  8  byte to transmit; stable from the tx_start cycle until the next tx_start.
REQ-012 fmt_busy  output  1  high whenever the FSM is not in S_IDLE.
REQ-013 resp_drop  output  1  sticky flag: a response pulse arrived while fmt_busy was high.

Function
REQ-014 Frame formats: OK = 'K'(0x4B), resp_addr; DATA = 'D'(0x44), resp_addr, resp_data_byte; ERR = 'E'(0x45), resp_err_code.
REQ-015 In S_IDLE, any pulse latches its frame type, addr, data and err_code into internal registers in that cycle and moves to S_SEND.
REQ-016 Simultaneous pulses: priority is err > data > ok; only one frame is latched; resp_drop is not set.
REQ-017 FSM states: S_IDLE, S_SEND, S_ACK, S_WAIT.
REQ-018 S_SEND: when tx_busy==0, drive tx_start=1 and tx_data=byte[idx], then go to S_ACK; otherwise stay in S_SEND.
REQ-019 S_ACK: stay until tx_busy==1, then go to S_WAIT.
REQ-020 S_WAIT: when tx_busy==0, either increment idx and go to S_SEND (if idx<len-1), or clear idx and go to S_IDLE.
REQ-021 idx is a 3-bit counter; frame len is 2 (K), 3 (D) or 2 (E); any unused idx value selects 0x00.
REQ-022 Pulse arriving while fmt_busy=1: ignored; resp_drop set to 1 in the next cycle; the frame in progress completes unaltered.
REQ-023 A pulse in the same cycle the FSM returns to S_IDLE counts as busy and is dropped.
REQ-024 tx_start is never high in two consecutive cycles; it is never asserted while tx_busy=1.
REQ-025 Minimum latency: pulse at cycle N gives first tx_start at N+1 when tx_busy=0.

Reset
REQ-026 On rst: state=S_IDLE, idx=0, tx_start=0, tx_data=0x00, fmt_busy=0, resp_drop=0, and latched frame registers=0.
REQ-027 rst mid-frame aborts immediately; the remaining bytes are not sent; pulses in a reset cycle are ignored.
REQ-028 resp_drop clears only on rst.

Configuration
REQ-029 Macro RESP_CRLF_EN: when defined, every frame gets 0x0D, 0x0A appended (len K=4, D=5, E=4); when undefined, no terminator is sent and the lengths are those in REQ-021.

Structure
REQ-030 Shared include file (resp_defs.vh): ASCII constants 'K','D','E','W','R', CR/LF, and error codes 0x01 (unknown cmd) and 0x02 (bad addr); command decoder and resp_formatter both use it.
REQ-031 One sub-module, resp_byte_sel: combinational; (frame type, idx, addr, data, err_code) -> byte; contains the RESP_CRLF_EN logic.

Verification
REQ-032 resp_ok, addr 0x05, tx model busy 10 cycles -> tx bytes 0x4B, 0x05; fmt_busy falls after the second byte; with CRLF: then 0x0D, 0x0A.
REQ-033 resp_data, addr 0x0A, data 0x3C -> bytes 0x44, 0x0A, 0x3C; tx_start pulses spaced by tx_busy.
REQ-034 resp_err, code 0x02 -> bytes 0x45, 0x02; resp_drop remains 0.
REQ-035 resp_ok and resp_err in the same cycle -> only 0x45, code sent; resp_drop=0.
REQ-036 resp_data mid-frame during OK frame -> OK frame intact; resp_drop=1 until rst.
REQ-037 rst asserted in S_WAIT of byte 1 -> no further tx_start; all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/resp_formatter_pkg.sv
// Shared response definitions: ASCII frame tags, CR/LF, error codes,
// frame/state types. Optional CR/LF terminator enabled by RESP_CRLF_EN.
package resp_formatter_pkg;

  // ASCII tags shared with the command decoder
  localparam logic [7:0] ASCII_K = 8'h4B;
  localparam logic [7:0] ASCII_D = 8'h44;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_W = 8'h57;
  localparam logic [7:0] ASCII_R = 8'h52;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Error codes reported in 'E' frames
  localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
  localparam logic [7:0] ERR_BAD_ADDR = 8'h02;

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_OK   = 2'd1,
    FT_DATA = 2'd2,
    FT_ERR  = 2'd3
  } frame_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Number of bytes in a frame of the given type
  function automatic logic [2:0] frame_len(frame_t ft);
    logic [2:0] len;
    unique case (ft)
      FT_DATA: len = 3'd3;
      FT_NONE: len = 3'd0;
      default: len = 3'd2;
    endcase
`ifdef RESP_CRLF_EN
    if (ft != FT_NONE) len = len + 3'd2;
`endif
    return len;
  endfunction

endpackage

// File: rtl/resp_byte_sel.sv
// Frame byte selector: picks the byte at position idx of the latched frame.
// Appends CR/LF after the payload when RESP_CRLF_EN is defined.
module resp_byte_sel
  import resp_formatter_pkg::*;
(
  input  frame_t     ft,
  input  logic [2:0] idx,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic [7:0] code,
  output logic [7:0] byte_o
);

  // Position decode per frame type; unused positions give 0x00
  always_comb begin
    byte_o = 8'h00;
    unique case (ft)
      FT_OK: begin
        case (idx)
          3'd0: byte_o = ASCII_K;
          3'd1: byte_o = addr;
`ifdef RESP_CRLF_EN
          3'd2: byte_o = ASCII_CR;
          3'd3: byte_o = ASCII_LF;
`endif
          default: byte_o = 8'h00;
        endcase
      end
      FT_DATA: begin
        case (idx)
          3'd0: byte_o = ASCII_D;
          3'd1: byte_o = addr;
          3'd2: byte_o = data;
`ifdef RESP_CRLF_EN
          3'd3: byte_o = ASCII_CR;
          3'd4: byte_o = ASCII_LF;
`endif
          default: byte_o = 8'h00;
        endcase
      end
      FT_ERR: begin
        case (idx)
          3'd0: byte_o = ASCII_E;
          3'd1: byte_o = code;
`ifdef RESP_CRLF_EN
          3'd2: byte_o = ASCII_CR;
          3'd3: byte_o = ASCII_LF;
`endif
          default: byte_o = 8'h00;
        endcase
      end
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/resp_formatter.sv
// Response formatter: turns completion pulses into K/D/E byte frames
// for a UART transmitter. Optional CR/LF terminator via RESP_CRLF_EN.
module resp_formatter
  import resp_formatter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       resp_ok,
  input  logic       resp_data,
  input  logic       resp_err,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data_byte,
  input  logic [7:0] resp_err_code,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       fmt_busy,
  output logic       resp_drop
);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  frame_t     ft_q, ft_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] code_q, code_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       drop_q, drop_d;
  logic       start_c;
  logic       any_pulse;
  logic [7:0] cur_byte;
  logic [2:0] last_idx;

  assign any_pulse = resp_ok | resp_data | resp_err;
  assign last_idx = frame_len(ft_q) - 3'd1;

  resp_byte_sel u_byte_sel (
    .ft    (ft_q),
    .idx   (idx_q),
    .addr  (addr_q),
    .data  (data_q),
    .code  (code_q),
    .byte_o(cur_byte)
  );

  // Next-state logic: latch frame, pace bytes on tx_busy, flag drops
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ft_d = ft_q;
    addr_d = addr_q;
    data_d = data_q;
    code_d = code_q;
    tx_data_d = tx_data_q;
    drop_d = drop_q;
    start_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_pulse) begin
          if (resp_err) ft_d = FT_ERR;
          else if (resp_data) ft_d = FT_DATA;
          else ft_d = FT_OK;
          addr_d = resp_addr;
          data_d = resp_data_byte;
          code_d = resp_err_code;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy && !rst) begin
          start_c = 1'b1;
          tx_data_d = cur_byte;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!tx_busy) begin
          if (idx_q < last_idx) begin
            idx_d = idx_q + 3'd1;
            state_d = S_SEND;
          end else begin
            idx_d = 3'd0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && any_pulse) drop_d = 1'b1;
  end

  // State and frame registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= 3'd0;
      ft_q <= FT_NONE;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      code_q <= 8'h00;
      tx_data_q <= 8'h00;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ft_q <= ft_d;
      addr_q <= addr_d;
      data_q <= data_d;
      code_q <= code_d;
      tx_data_q <= tx_data_d;
      drop_q <= drop_d;
    end
  end

  // tx_data holds the last issued byte between starts
  assign tx_start = start_c;
  assign tx_data = start_c ? cur_byte : tx_data_q;
  assign fmt_busy = (state_q != S_IDLE);
  assign resp_drop = drop_q;

endmodule

// File: tb/tb_resp_formatter.sv
// Testbench for resp_formatter: vector table plus scoreboard of
// expected UART bytes, and hand sequences for drop and reset cases.
module tb_resp_formatter;

  localparam int BUSY = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       resp_ok = 1'b0;
  logic       resp_data = 1'b0;
  logic       resp_err = 1'b0;
  logic [7:0] resp_addr = 8'h00;
  logic [7:0] resp_data_byte = 8'h00;
  logic [7:0] resp_err_code = 8'h00;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       fmt_busy;
  logic       resp_drop;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];

  resp_formatter dut (
    .clk           (clk),
    .rst           (rst),
    .resp_ok       (resp_ok),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .resp_addr     (resp_addr),
    .resp_data_byte(resp_data_byte),
    .resp_err_code (resp_err_code),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .fmt_busy      (fmt_busy),
    .resp_drop     (resp_drop)
  );

  always #5 clk = ~clk;

  // UART model: busy from the cycle after tx_start for BUSY cycles
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every tx_start pops the scoreboard
  always @(negedge clk) begin
    if (tx_start) begin
      chk("start_rules", {6'd0, tx_busy, prev_start}, 8'h00);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got %02h expected none", tx_data);
      end else begin
        chk("tx_byte", tx_data, exp_q.pop_front());
      end
    end
    prev_start = tx_start;
  end

  typedef struct {
    logic       ok;
    logic       dat;
    logic       err;
    logic [7:0] addr;
    logic [7:0] db;
    logic [7:0] code;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
  } vec_t;

  vec_t vecs[6];

  task automatic push_frame(input vec_t v);
    exp_q.push_back(v.b0);
    exp_q.push_back(v.b1);
    if (v.n == 3) exp_q.push_back(v.b2);
`ifdef RESP_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic pulse(input logic ok, input logic dat, input logic err,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] c);
    resp_ok = ok;
    resp_data = dat;
    resp_err = err;
    resp_addr = a;
    resp_data_byte = d;
    resp_err_code = c;
    @(negedge clk);
    resp_ok = 1'b0;
    resp_data = 1'b0;
    resp_err = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((fmt_busy || exp_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL %s_timeout: got busy expected idle", name);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 8'h05, 8'h00, 8'h00, 8'h4B, 8'h05, 8'h00, 2};
    vecs[1] = '{0, 1, 0, 8'h0A, 8'h3C, 8'h00, 8'h44, 8'h0A, 8'h3C, 3};
    vecs[2] = '{0, 0, 1, 8'h33, 8'h00, 8'h02, 8'h45, 8'h02, 8'h00, 2};
    vecs[3] = '{1, 0, 1, 8'h11, 8'h00, 8'h01, 8'h45, 8'h01, 8'h00, 2};
    vecs[4] = '{1, 1, 1, 8'h22, 8'h77, 8'h02, 8'h45, 8'h02, 8'h00, 2};
    vecs[5] = '{1, 1, 0, 8'hF0, 8'h9A, 8'h01, 8'h44, 8'hF0, 8'h9A, 3};

    repeat (3) @(negedge clk);
    chk("rst_tx_start", {7'd0, tx_start}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_fmt_busy", {7'd0, fmt_busy}, 8'h00);
    chk("rst_drop", {7'd0, resp_drop}, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      push_frame(vecs[i]);
      pulse(vecs[i].ok, vecs[i].dat, vecs[i].err,
            vecs[i].addr, vecs[i].db, vecs[i].code);
      chk($sformatf("latency_%0d", i), {7'd0, tx_start}, 8'h01);
      chk($sformatf("busy_%0d", i), {7'd0, fmt_busy}, 8'h01);
      wait_done($sformatf("vec_%0d", i));
      chk($sformatf("idle_%0d", i), {7'd0, fmt_busy}, 8'h00);
      chk($sformatf("nodrop_%0d", i), {7'd0, resp_drop}, 8'h00);
      repeat (3) @(negedge clk);
    end

    // Pulse mid-frame: dropped, frame intact, flag sticky
    push_frame(vecs[0]);
    pulse(1, 0, 0, 8'h05, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    pulse(0, 1, 0, 8'hAA, 8'h55, 8'h00);
    chk("drop_set", {7'd0, resp_drop}, 8'h01);
    wait_done("midframe");
    repeat (20) @(negedge clk);
    chk("drop_sticky", {7'd0, resp_drop}, 8'h01);
    do_reset();
    chk("drop_cleared", {7'd0, resp_drop}, 8'h00);
    repeat (15) @(negedge clk);

    // Pulse on the cycle the FSM returns to idle is dropped
    push_frame(vecs[0]);
    pulse(1, 0, 0, 8'h05, 8'h00, 8'h00);
    begin
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !tx_busy) && t < 500) begin
        @(negedge clk);
        t++;
      end
      while (tx_busy && t < 500) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (t >= 500) begin
        errors++;
        $display("FAIL edge_timeout: got busy expected idle");
      end
    end
    chk("edge_busy", {7'd0, fmt_busy}, 8'h01);
    pulse(0, 1, 0, 8'h99, 8'h88, 8'h00);
    chk("edge_idle", {7'd0, fmt_busy}, 8'h00);
    chk("edge_drop", {7'd0, resp_drop}, 8'h01);
    repeat (15) @(negedge clk);
    do_reset();
    repeat (15) @(negedge clk);

    // Reset in S_WAIT of byte 1 aborts the frame
    push_frame(vecs[1]);
    pulse(0, 1, 0, 8'h0A, 8'h3C, 8'h00);
    repeat (2) @(negedge clk);
    chk("abort_pre", {7'd0, fmt_busy}, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_start", {7'd0, tx_start}, 8'h00);
    chk("abort_data", tx_data, 8'h00);
    chk("abort_busy", {7'd0, fmt_busy}, 8'h00);
    chk("abort_drop", {7'd0, resp_drop}, 8'h00);
    repeat (40) @(negedge clk);
    chk("abort_quiet", {7'd0, fmt_busy}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
